// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 2-flop input synchronizer, byte-valid pulse and framing-error pulse.
// Build option: define UART_RX_MAJORITY_EN for 2-of-3 majority sampling (all decisions one cycle later).
module uart_receiver #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic       clc,
    input  logic       res,
    input  logic       RX,
    output logic [7:0] word_receiver,
    output logic       priznak_end_receiver,
    output logic       framing_error,
    output logic       busy
);

    if (DATA_BITS != 8) begin : g_bad_data_bits
        $error("uart_receiver: DATA_BITS must be 8");
    end
    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 1023) begin : g_bad_clks_per_bit
        $error("uart_receiver: CLKS_PER_BIT must be in 4..1023");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    localparam logic [9:0] LAST_CNT  = 10'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [9:0] START_CNT = 10'(CLKS_PER_BIT / 2);
`else
    localparam logic [9:0] START_CNT = 10'(CLKS_PER_BIT / 2 - 1);
`endif

    state_t      state_q, state_d;
    logic        sync1_q, sync1_d;
    logic        rx_s_q, rx_s_d;
    logic        rx_prev_q, rx_prev_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  word_q, word_d;
    logic        done_q, done_d;
    logic        ferr_q, ferr_d;
    logic        sample_bit;
    logic        fall_edge;
    logic        start_hit;
    logic        bit_hit;

`ifdef UART_RX_MAJORITY_EN
    logic        rx_prev2_q, rx_prev2_d;

    // Evaluated one cycle after the nominal point, so rx_prev_q is the nominal sample.
    assign sample_bit = (rx_s_q & rx_prev_q) | (rx_s_q & rx_prev2_q) | (rx_prev_q & rx_prev2_q);
    assign rx_prev2_d = rx_prev_q;

    always_ff @(posedge clc or negedge res) begin
        if (!res) begin
            rx_prev2_q <= 1'b1;
        end else begin
            rx_prev2_q <= rx_prev2_d;
        end
    end
`else
    assign sample_bit = rx_s_q;
`endif

    assign sync1_d   = RX;
    assign rx_s_d    = sync1_q;
    assign rx_prev_d = rx_s_q;
    assign fall_edge = rx_prev_q & ~rx_s_q;
    assign start_hit = (cnt_q == START_CNT);
    assign bit_hit   = (cnt_q == LAST_CNT);

    always_ff @(posedge clc or negedge res) begin
        if (!res) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fall_edge) state_d = START;
            START:   if (start_hit) state_d = sample_bit ? IDLE : DATA;
            DATA:    if (bit_hit && bit_q == 3'd7) state_d = STOP;
            STOP:    if (bit_hit) state_d = sample_bit ? IDLE : BREAK;
            BREAK:   if (rx_s_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        word_d = word_q;
        done_d = 1'b0;
        ferr_d = 1'b0;
        busy   = (state_q != IDLE);
        if (state_q == STOP && bit_hit) begin
            if (sample_bit) begin
                done_d = 1'b1;
                word_d = shift_q;
            end else begin
                ferr_d = 1'b1;
            end
        end
    end

    // The cycle counter only advances inside a frame; it never wraps on its own.
    always_comb begin
        cnt_d   = cnt_q + 10'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            START: begin
                if (start_hit) begin
                    cnt_d = '0;
                    bit_d = '0;
                end
            end
            DATA: begin
                if (bit_hit) begin
                    cnt_d   = '0;
                    bit_d   = bit_q + 3'd1;
                    shift_d = {sample_bit, shift_q[7:1]};
                end
            end
            STOP: begin
                if (bit_hit) cnt_d = '0;
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clc or negedge res) begin
        if (!res) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            word_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            rx_s_q    <= rx_s_d;
            rx_prev_q <= rx_prev_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            word_q    <= word_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
        end
    end

    assign word_receiver        = word_q;
    assign priznak_end_receiver = done_q;
    assign framing_error        = ferr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: scoreboard of expected pulses (kind, word, cycle) checked by a monitor.
module tb_uart_receiver;

    localparam int C = 16;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    // Cycles from the RX pin falling edge (negedge stamp) to the pulse, incl. synchronizer.
    localparam int LAT = 155 + MAJ;

    logic       clc = 1'b0;
    logic       res = 1'b0;
    logic       RX  = 1'b1;
    logic [7:0] word_receiver;
    logic       priznak_end_receiver;
    logic       framing_error;
    logic       busy;

    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_word = 8'h00;

    typedef struct {
        bit         is_err;
        logic [7:0] word;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    uart_receiver #(.CLKS_PER_BIT(C), .DATA_BITS(8)) dut (
        .clc                  (clc),
        .res                  (res),
        .RX                   (RX),
        .word_receiver        (word_receiver),
        .priznak_end_receiver (priznak_end_receiver),
        .framing_error        (framing_error),
        .busy                 (busy)
    );

    always #5 clc = ~clc;
    always @(posedge clc) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Drives ncyc cycles of a 10-bit frame; glitch_k inverts the line for that one cycle.
    task automatic drive_frame(input logic [7:0] data, input logic stopb, input int glitch_k, input int ncyc);
        logic [9:0] frame;
        frame = {stopb, data, 1'b0};
        for (int k = 0; k < ncyc; k++) begin
            RX = (k == glitch_k) ? ~frame[k / C] : frame[k / C];
            @(negedge clc);
        end
    endtask

    task automatic send(input logic [7:0] data, input logic stopb, input int glitch_k, input logic [7:0] got_word);
        exp_t e;
        e.is_err = !stopb;
        e.cyc    = cyc + LAT;
        if (stopb) exp_word = got_word;
        e.word   = exp_word;
        sb.push_back(e);
        drive_frame(data, stopb, glitch_k, 10 * C);
    endtask

    initial begin
        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clc);
                    if (priznak_end_receiver || framing_error) begin
                        chk("pulse_exclusive", priznak_end_receiver & framing_error, 0);
                        checks++;
                        assert (sb.size() > 0) else begin
                            errors++;
                            $error("FAIL unexpected_pulse: observed pulse done=%0b ferr=%0b at cycle %0d, expected none",
                                   priznak_end_receiver, framing_error, cyc);
                        end
                        if (sb.size() > 0) begin
                            e = sb.pop_front();
                            chk("pulse_kind_ferr", framing_error, e.is_err);
                            chk("pulse_cycle", cyc, e.cyc);
                            chk("pulse_word", word_receiver, e.word);
                        end
                    end
                end
            end
        join_none

        res = 1'b0;
        RX  = 1'b1;
        repeat (3) @(negedge clc);
        chk("reset_word", word_receiver, 8'h00);
        chk("reset_done", priznak_end_receiver, 0);
        chk("reset_ferr", framing_error, 0);
        chk("reset_busy", busy, 0);
        res = 1'b1;
        repeat (20) @(negedge clc);

        // Single frame 0xA5 with busy profile.
        fork
            send(8'hA5, 1'b1, -1, 8'hA5);
            begin
                repeat (3) @(negedge clc);
                chk("busy_start", busy, 1);
                repeat (97) @(negedge clc);
                chk("busy_mid", busy, 1);
                repeat (54 + MAJ) @(negedge clc);
                chk("busy_stop_decision", busy, 1);
                @(negedge clc);
                chk("busy_after_stop", busy, 0);
            end
        join
        repeat (20) @(negedge clc);

        // Three-cycle low glitch on an idle line.
        RX = 1'b0;
        repeat (3) @(negedge clc);
        RX = 1'b1;
        chk("glitch_busy_start", busy, 1);
        repeat (7 + MAJ) @(negedge clc);
        chk("glitch_busy_at_sample", busy, 1);
        @(negedge clc);
        chk("glitch_busy_cleared", busy, 0);
        repeat (20) @(negedge clc);
        chk("glitch_word_held", word_receiver, exp_word);

        // Framing error, held break, then recovery.
        send(8'h3C, 1'b0, -1, 8'h00);
        repeat (40) @(negedge clc);
        chk("break_busy", busy, 1);
        RX = 1'b1;
        repeat (20) @(negedge clc);
        chk("break_released", busy, 0);
        chk("break_word_held", word_receiver, 8'hA5);
        send(8'h81, 1'b1, -1, 8'h81);
        repeat (20) @(negedge clc);

        // Back-to-back frames with no idle bits.
        send(8'h00, 1'b1, -1, 8'h00);
        send(8'hFF, 1'b1, -1, 8'hFF);
        send(8'h55, 1'b1, -1, 8'h55);
        repeat (20) @(negedge clc);

        // Reset in the middle of data bit 4.
        drive_frame(8'h99, 1'b1, -1, 5 * C + 8);
        res = 1'b0;
        repeat (2) @(negedge clc);
        chk("midreset_word", word_receiver, 8'h00);
        chk("midreset_done", priznak_end_receiver, 0);
        chk("midreset_ferr", framing_error, 0);
        chk("midreset_busy", busy, 0);
        exp_word = 8'h00;
        RX = 1'b1;
        repeat (5) @(negedge clc);
        res = 1'b1;
        repeat (20) @(negedge clc);
        send(8'h7E, 1'b1, -1, 8'h7E);
        repeat (20) @(negedge clc);

        // One-cycle high glitch at the nominal sample of data bit 3.
        send(8'h00, 1'b1, 72, (MAJ != 0) ? 8'h00 : 8'h08);

        repeat (200) @(negedge clc);
        chk("scoreboard_empty", sb.size(), 0);
        chk("final_word", word_receiver, exp_word);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver, 8N1, LSB first: one start bit (0), 8 data bits, one stop bit (1). Line idles high.
- Sits directly downstream of the team's UART transmitter: its RX input is the transmitter's TX line, either looped back on the Cyclone IV board or taken from an external pin.
- Runs on an oversampling clock, CLKS_PER_BIT cycles per bit. Delivers each received byte with a one-cycle completion pulse and flags framing errors.

Parameters:
- CLKS_PER_BIT, 16: clc cycles per UART bit. Legal range is 4 to 1023. H = CLKS_PER_BIT/2, integer division.
- DATA_BITS, 8: data bits per frame. Fixed at 8; any other value is a compile-time error.

Ports:
- clc  input  1  system clock; all logic on the rising edge.
- res  input  1  asynchronous, active-low reset.
- RX  input  1  serial line, asynchronous to clc.
- word_receiver  output  8  last correctly received byte.
- priznak_end_receiver  output  1  one-cycle pulse: new byte valid on word_receiver.
- framing_error  output  1  one-cycle pulse: stop bit sampled as 0.
- busy  output  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- Interface (decided): one clock, clc. Reset res is asynchronous, active-low.
- Reset values: word_receiver=0, priznak_end_receiver=0, framing_error=0, busy=0. Synchronizer flops=1, state=IDLE, bit counter=0, cycle counter=0.
- Input: RX passes through a 2-flop synchronizer, giving rx_s. All decisions use rx_s.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - t0 is the cycle in which rx_s=0 and its previous value was 1.
  - At t0: enter START, clear cycle counter.
- START:
  - Sample at t0+H.
  - Sample 0: enter DATA, clear cycle and bit counters.
  - Sample 1: glitch; return to IDLE with no output activity.
- DATA:
  - Bit i (i=0..7) is sampled at t0+H+(i+1)*CLKS_PER_BIT and shifted in LSB first.
  - After bit 7: enter STOP.
- STOP:
  - Sample at t0+H+9*CLKS_PER_BIT.
  - Sample 1: in the next cycle word_receiver takes the shift register value and priznak_end_receiver=1 for exactly one cycle; return to IDLE. This early return allows back-to-back frames with zero idle bits.
  - Sample 0: in the next cycle framing_error=1 for exactly one cycle; word_receiver unchanged; enter BREAK.
- BREAK:
  - Stay until rx_s=1, then go to IDLE.
  - A continuously low line produces no further errors or pulses.
- Outputs:
  - word_receiver holds its value until the next good frame.
  - priznak_end_receiver and framing_error are never high in the same cycle.
- Latency: priznak_end_receiver is high in cycle t0+H+9*CLKS_PER_BIT+1 (t0+153 for the default). Add 2 clc cycles for the synchronizer, measured from the RX pin edge.
- Reset mid-frame:
  - Immediate return to IDLE with all outputs at reset values.
  - After release, a low RX does not start a frame until a 1→0 transition is seen on rx_s. The synchronizer resets to 1, so a line still low at release counts as a falling edge. This is accepted.
- Counters:
  - Cycle counter is 10 bits and wraps only via an explicit clear.
  - Bit counter is 3 bits.
- No flow control and no buffering. The consumer must capture word_receiver within CLKS_PER_BIT*10 cycles of the pulse.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: every sample point (start, data, stop) uses a 2-of-3 majority vote of rx_s at sample-1, sample and sample+1. The decision and all state transitions happen at sample+1, so every timing above shifts by +1 cycle (priznak_end_receiver at t0+154 for the default).
- Undefined: single sample of rx_s at the nominal point; timings exactly as in Behaviour.

Test Plan:
- CLKS_PER_BIT=16, send 0xA5, idle before and after → word_receiver=0xA5; one priznak_end_receiver pulse at t0+153 (t0+154 with macro); framing_error stays 0; busy high from t0 through the STOP decision.
- RX low for 3 cycles, then high → no state change past START, busy low again by t0+9, no pulses, word_receiver unchanged.
- Send 0x3C with stop bit forced 0, hold RX low for 40 cycles, then send 0x81 → one framing_error pulse, word_receiver stays at its previous value, no further activity while low, then 0x81 received correctly.
- Back-to-back 0x00, 0xFF, 0x55 with no idle bits → three pulses spaced exactly 160 cycles apart with values 0x00, 0xFF, 0x55.
- Assert res at data bit 4 of a frame, release, then send 0x7E → outputs at reset values during reset; next pulse carries 0x7E.
- Single-cycle 1-glitch exactly at the nominal sample of data bit 3 of 0x00 → with UART_RX_MAJORITY_EN: 0x00; without: 0x08.
